// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 16-bit external SRAM controller.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2,
        ST_DONE   = 2'd3
    } sram_state_e;

    localparam int unsigned DEF_BASE_ADDR = 1024;
    localparam int unsigned HALF_W        = 16;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that times one half-word phase on the SRAM pins.
module sram_wait_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             last_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/sram_mem_controller.sv
// Splits each 32-bit MEM-stage load/store into two half-word SRAM accesses,
// holding the pipeline off through 'ready' until the word is complete.
module sram_mem_controller
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned SRAM_AW     = 17,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic [31:0]        in_address,
    input  logic [31:0]        WriteData,
    output logic [31:0]        ReadData,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [HALF_W-1:0]  sram_wdata,
    input  logic [HALF_W-1:0]  sram_rdata,
    output logic               sram_we_n
);

    localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);
    localparam int unsigned WW = SRAM_AW - 1;

    sram_state_e        state_q;
    logic [WW-1:0]      word_q;
    logic [HALF_W-1:0]  lo_q;
    logic               wr_q;
    logic [31:0]        rdata_q;
    logic [SRAM_AW-1:0] addr_q;
    logic [HALF_W-1:0]  wdata_q;
    logic               we_n_q;

    logic          req;
    logic [WW-1:0] word;
    logic          last;
    logic          cnt_load;
    logic          cnt_en;

    assign req  = MemRead | MemWrite;
    // Word index wraps modulo the SRAM depth; the two byte-offset bits are dropped.
    assign word = WW'((in_address - 32'(BASE_ADDR)) >> 2);

    assign cnt_load = ((state_q == ST_IDLE) && req) || ((state_q == ST_FIRST) && last);
    assign cnt_en   = (state_q == ST_FIRST) || (state_q == ST_SECOND);

    sram_wait_counter #(
        .WIDTH (CW)
    ) u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (CW'(WAIT_CYCLES)),
        .en_i       (cnt_en),
        .last_o     (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            lo_q    <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_n_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_q <= ST_FIRST;
                        word_q  <= word;
                        lo_q    <= WriteData[15:0];
                        wr_q    <= MemWrite;
                        addr_q  <= {word, 1'b0};
                        wdata_q <= WriteData[31:16];
                        we_n_q  <= ~MemWrite;
                    end
                end
                ST_FIRST: begin
                    if (last) begin
                        if (!wr_q) begin
                            rdata_q[31:16] <= sram_rdata;
                        end
                        state_q <= ST_SECOND;
                        addr_q  <= {word_q, 1'b1};
                        wdata_q <= lo_q;
                        we_n_q  <= ~wr_q;
                    end
                end
                ST_SECOND: begin
                    if (last) begin
                        if (!wr_q) begin
                            rdata_q[15:0] <= sram_rdata;
                        end
                        state_q <= ST_DONE;
                        we_n_q  <= 1'b1;
                    end
                end
                // A request still held here belongs to the access just finished.
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    we_n_q  <= 1'b1;
                end
            endcase
        end
    end

    assign ready      = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);
    assign ReadData   = rdata_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign sram_we_n  = we_n_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Scoreboard bench for sram_mem_controller with a behavioural 16-bit SRAM.
module tb_sram_mem_controller;

    localparam int unsigned AW = 17;

    logic          clk;
    logic          rst;
    logic          MemRead;
    logic          MemWrite;
    logic [31:0]   in_address;
    logic [31:0]   WriteData;
    logic [31:0]   ReadData;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_wdata;
    logic [15:0]   sram_rdata;
    logic          sram_we_n;

    logic [15:0]   mem [0:(1<<AW)-1];
    logic [31:0]   shadow [int];
    logic [31:0]   exp_q [$];
    logic [31:0]   last_load;

    int total;
    int bad;

    sram_mem_controller #(
        .BASE_ADDR   (1024),
        .SRAM_AW     (AW),
        .WAIT_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .in_address (in_address),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_we_n  (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr] <= sram_wdata;
    end
    assign sram_rdata = mem[sram_addr];

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return int'((off >> 2) & 32'h0000_FFFF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input int drop_at, input string tag);
        int n;
        int we_low;
        int w;
        logic [31:0] e;
        w = word_of(addr);
        @(posedge clk);
        #1;
        in_address = addr;
        WriteData  = data;
        MemRead    = rd;
        MemWrite   = wr;
        if (wr) shadow[w] = data;
        else    exp_q.push_back(shadow[w]);
        n = 0;
        we_low = 0;
        @(negedge clk);
        chk({tag, "_rdy0"}, 32'(ready), 32'd0);
        while (1) begin
            @(posedge clk);
            n++;
            if (n == drop_at) begin
                #1;
                MemRead  = 1'b0;
                MemWrite = 1'b0;
            end
            @(negedge clk);
            if (!sram_we_n) we_low++;
            if (n == 1) chk({tag, "_addr_hi"}, 32'(sram_addr), 32'(w * 2));
            if (n == 3) chk({tag, "_addr_lo"}, 32'(sram_addr), 32'(w * 2 + 1));
            if (ready || n >= 20) break;
        end
        chk({tag, "_lat"}, n, 5);
        chk({tag, "_we_cycles"}, we_low, wr ? 4 : 0);
        if (wr) begin
            chk({tag, "_rd_hold"}, ReadData, last_load);
            chk({tag, "_sram_hi"}, 32'(mem[w*2]), 32'(data[31:16]));
            chk({tag, "_sram_lo"}, 32'(mem[w*2+1]), 32'(data[15:0]));
        end else begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            chk({tag, "_rdata"}, ReadData, e);
            last_load = e;
        end
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_rdy"}, 32'(ready), 32'd1);
        chk({tag, "_idle_we"}, 32'(sram_we_n), 32'd1);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        last_load  = '0;
        rst        = 1'b1;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        in_address = '0;
        WriteData  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_rdata", ReadData, 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);

        access(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 0, "wr1024");
        access(1'b1, 1'b0, 32'd1024, 32'h0, 0, "rd1024");
        access(1'b0, 1'b1, 32'd1028, 32'h1234_5678, 0, "wr1028");
        access(1'b1, 1'b0, 32'd1024, 32'h0, 0, "rd1024b");
        access(1'b1, 1'b0, 32'd1028, 32'h0, 0, "rd1028");

        // Mid-cycle reset clears the registered outputs without waiting for an edge.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_rdata", ReadData, 32'd0);
        chk("midrst_we_n", 32'(sram_we_n), 32'd1);
        chk("midrst_ready", 32'(ready), 32'd1);
        last_load = '0;
        @(posedge clk);
        #1 rst = 1'b0;

        access(1'b0, 1'b1, 32'd1036, 32'hA5A5_5A5A, 1, "wr_drop");
        access(1'b1, 1'b0, 32'd1036, 32'h0, 0, "rd_drop");
        access(1'b1, 1'b1, 32'd1040, 32'h0BAD_F00D, 0, "both");
        access(1'b1, 1'b0, 32'd1040, 32'h0, 0, "rd_both");
        access(1'b0, 1'b1, 32'd1024 + 32'h0004_0000, 32'h55AA_33CC, 0, "wr_wrap");
        access(1'b1, 1'b0, 32'd1024, 32'h0, 0, "rd_wrap");

        access(1'b0, 1'b1, 32'd1032, 32'h1111_2222, 0, "wr1032");
        // Abort a store during its second phase: high half lands, low half keeps old data.
        @(posedge clk);
        #1;
        in_address = 32'd1032;
        WriteData  = 32'hCAFE_F00D;
        MemWrite   = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("abort_we_before", 32'(sram_we_n), 32'd0);
        rst      = 1'b1;
        MemWrite = 1'b0;
        #1;
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_ready", 32'(ready), 32'd1);
        last_load = '0;
        shadow[word_of(32'd1032)] = 32'hCAFE_2222;
        @(posedge clk);
        #1 rst = 1'b0;
        access(1'b1, 1'b0, 32'd1032, 32'h0, 0, "rd_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
